// File: rtl/exc_mode_ctrl_pkg.sv
// Shared constants for the exception/mode sequencer: mode codes, FSM state
// codes, exception kinds, default vectors and the banked link-register index.
package ctrl_pkg;

   localparam int ADDR_W = 4;
   localparam int SIZE_W = 32;

   localparam logic [4:0] MODE_USR = 5'b10000;
   localparam logic [4:0] MODE_FIQ = 5'b10001;
   localparam logic [4:0] MODE_IRQ = 5'b10010;
   localparam logic [4:0] MODE_SVC = 5'b10011;

   typedef logic [2:0] state_t;
   localparam state_t ST_RST_VEC = 3'd0;
   localparam state_t ST_IDLE    = 3'd1;
   localparam state_t ST_SAVE    = 3'd2;
   localparam state_t ST_JUMP    = 3'd3;
   localparam state_t ST_RET_RD  = 3'd4;
   localparam state_t ST_RET_PC  = 3'd5;

   typedef enum logic [1:0] {
      EXC_FIQ = 2'd0,
      EXC_IRQ = 2'd1,
      EXC_SWI = 2'd2,
      EXC_RET = 2'd3
   } exc_kind_e;

   localparam logic [31:0] DEF_VEC_RST = 32'h00;
   localparam logic [31:0] DEF_VEC_SWI = 32'h08;
   localparam logic [31:0] DEF_VEC_IRQ = 32'h18;
   localparam logic [31:0] DEF_VEC_FIQ = 32'h1C;

   localparam logic [3:0] DEF_LR_ADDR = 4'd14;

endpackage

// File: rtl/exc_mode_ctrl_if.sv
// Sequencer <-> register-file/datapath bundle.
// master: controller side (requests/PC/Lr_Data in; M, PC and reg-write controls out).
// slave : register file / datapath side.
interface exc_mode_ctrl_if #(
   parameter int ADDR = 4,
   parameter int SIZE = 32
);
   logic            Fiq_Req;
   logic            Irq_Req;
   logic            Swi_Req;
   logic            Ret_Req;
   logic [SIZE-1:0] PC;
   logic [SIZE-1:0] Lr_Data;
   logic [4:0]      M;
   logic            Write_PC;
   logic [SIZE-1:0] PC_New;
   logic            Write_Reg;
   logic [ADDR-1:0] W_Addr;
   logic [SIZE-1:0] W_Data;
   logic [ADDR-1:0] Rd_Addr;
   logic            Stall;
   logic [1:0]      Mask;

   modport master (
      input  Fiq_Req, Irq_Req, Swi_Req, Ret_Req,
      input  PC, Lr_Data,
      output M, Write_PC, PC_New, Write_Reg,
      output W_Addr, W_Data, Rd_Addr, Stall, Mask
   );

   modport slave (
      output Fiq_Req, Irq_Req, Swi_Req, Ret_Req,
      output PC, Lr_Data,
      input  M, Write_PC, PC_New, Write_Reg,
      input  W_Addr, W_Data, Rd_Addr, Stall, Mask
   );
endinterface

// File: rtl/exc_mode_ctrl_prio_enc.sv
// Priority/mask encoder: FIQ (F=0) > IRQ (I=0) > SWI > RET (not from USR).
// Ports: request levels, mask_i={F,I}, mode_i; take_o and kind_o out.
module exc_prio_enc
   import ctrl_pkg::*;
(
   input  logic       fiq_i,
   input  logic       irq_i,
   input  logic       swi_i,
   input  logic       ret_i,
   input  logic [1:0] mask_i,
   input  logic [4:0] mode_i,
   output logic       take_o,
   output exc_kind_e  kind_o
);

   always_comb begin
      take_o = 1'b0;
      kind_o = EXC_FIQ;
      priority case (1'b1)
         fiq_i && !mask_i[1]: begin
            take_o = 1'b1;
            kind_o = EXC_FIQ;
         end
         irq_i && !mask_i[0]: begin
            take_o = 1'b1;
            kind_o = EXC_IRQ;
         end
         swi_i: begin
            take_o = 1'b1;
            kind_o = EXC_SWI;
         end
         ret_i && (mode_i != MODE_USR): begin
            take_o = 1'b1;
            kind_o = EXC_RET;
         end
         default: begin
            take_o = 1'b0;
            kind_o = EXC_FIQ;
         end
      endcase
   end

endmodule

// File: rtl/exc_mode_ctrl.sv
// Exception/mode sequencer for the banked register file. Build option: SPSR_EN.
// Ports: Clk, Rst (sync, active-high), bus (exc_mode_ctrl_if.master).
module exc_mode_ctrl
   import ctrl_pkg::*;
#(
   parameter int              ADDR    = ADDR_W,
   parameter int              SIZE    = SIZE_W,
   parameter logic [ADDR-1:0] LR_ADDR = DEF_LR_ADDR,
   parameter logic [SIZE-1:0] VEC_RST = DEF_VEC_RST,
   parameter logic [SIZE-1:0] VEC_SWI = DEF_VEC_SWI,
   parameter logic [SIZE-1:0] VEC_IRQ = DEF_VEC_IRQ,
   parameter logic [SIZE-1:0] VEC_FIQ = DEF_VEC_FIQ
) (
   input logic              Clk,
   input logic              Rst,
   exc_mode_ctrl_if.master  bus
);

   state_t          state_q, state_d;
   logic [4:0]      m_q, m_d;
   logic [1:0]      mask_q, mask_d;
   logic [SIZE-1:0] ret_q, ret_d;
   logic [SIZE-1:0] pcn_q, pcn_d;
   logic            take;
   exc_kind_e       kind;
   logic [6:0]      restore;

   exc_prio_enc u_prio (
      .fiq_i  (bus.Fiq_Req),
      .irq_i  (bus.Irq_Req),
      .swi_i  (bus.Swi_Req),
      .ret_i  (bus.Ret_Req),
      .mask_i (mask_q),
      .mode_i (m_q),
      .take_o (take),
      .kind_o (kind)
   );

`ifdef SPSR_EN
   logic [6:0] spsr_fiq_q, spsr_fiq_d;
   logic [6:0] spsr_irq_q, spsr_irq_d;
   logic [6:0] spsr_svc_q, spsr_svc_d;

   always_comb begin
      unique case (m_q)
         MODE_FIQ: restore = spsr_fiq_q;
         MODE_IRQ: restore = spsr_irq_q;
         MODE_SVC: restore = spsr_svc_q;
         default:  restore = {2'b00, MODE_USR};
      endcase
   end
`else
   assign restore = {2'b00, MODE_USR};
`endif

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      mask_d  = mask_q;
      ret_d   = ret_q;
      pcn_d   = pcn_q;
`ifdef SPSR_EN
      spsr_fiq_d = spsr_fiq_q;
      spsr_irq_d = spsr_irq_q;
      spsr_svc_d = spsr_svc_q;
`endif
      unique case (state_q)
         ST_RST_VEC: state_d = ST_IDLE;
         ST_IDLE: begin
            if (take) begin
               if (kind == EXC_RET) begin
                  state_d = ST_RET_RD;
               end else begin
                  state_d = ST_SAVE;
                  ret_d   = bus.PC;
               end
               unique case (kind)
                  EXC_FIQ: begin
                     m_d    = MODE_FIQ;
                     mask_d = 2'b11;
                     pcn_d  = VEC_FIQ;
`ifdef SPSR_EN
                     spsr_fiq_d = {mask_q, m_q};
`endif
                  end
                  EXC_IRQ: begin
                     m_d    = MODE_IRQ;
                     mask_d = {mask_q[1], 1'b1};
                     pcn_d  = VEC_IRQ;
`ifdef SPSR_EN
                     spsr_irq_d = {mask_q, m_q};
`endif
                  end
                  EXC_SWI: begin
                     m_d    = MODE_SVC;
                     mask_d = {mask_q[1], 1'b1};
                     pcn_d  = VEC_SWI;
`ifdef SPSR_EN
                     spsr_svc_d = {mask_q, m_q};
`endif
                  end
                  default: ;
               endcase
            end
         end
         ST_SAVE:   state_d = ST_JUMP;
         ST_JUMP:   state_d = ST_IDLE;
         ST_RET_RD: begin
            pcn_d   = bus.Lr_Data;
            state_d = ST_RET_PC;
         end
         ST_RET_PC: begin
            {mask_d, m_d} = restore;
            state_d       = ST_IDLE;
         end
         default:   state_d = ST_RST_VEC;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_RST_VEC;
         m_q     <= MODE_SVC;
         mask_q  <= 2'b11;
         ret_q   <= '0;
         pcn_q   <= VEC_RST;
`ifdef SPSR_EN
         spsr_fiq_q <= {2'b00, MODE_USR};
         spsr_irq_q <= {2'b00, MODE_USR};
         spsr_svc_q <= {2'b00, MODE_USR};
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         mask_q  <= mask_d;
         ret_q   <= ret_d;
         pcn_q   <= pcn_d;
`ifdef SPSR_EN
         spsr_fiq_q <= spsr_fiq_d;
         spsr_irq_q <= spsr_irq_d;
         spsr_svc_q <= spsr_svc_d;
`endif
      end
   end

   assign bus.M        = m_q;
   assign bus.Mask     = mask_q;
   assign bus.PC_New   = pcn_q;
   assign bus.W_Data   = ret_q;
   assign bus.W_Addr   = LR_ADDR;
   assign bus.Rd_Addr  = LR_ADDR;
   assign bus.Stall    = (state_q != ST_IDLE);
   assign bus.Write_PC = (state_q == ST_RST_VEC) ||
                         (state_q == ST_JUMP) ||
                         (state_q == ST_RET_PC);
   // A reset landing on the SAVE edge must not commit the LR write.
   assign bus.Write_Reg = (state_q == ST_SAVE) && !Rst;

endmodule

// File: tb/tb_exc_mode_ctrl.sv
// Directed table-driven bench for exc_mode_ctrl (default and SPSR_EN builds).
// Each row: inputs driven at negedge, outputs checked 1 time unit after posedge.
module tb_exc_mode_ctrl;

   localparam logic [4:0] U = 5'h10;
   localparam logic [4:0] F = 5'h11;
   localparam logic [4:0] I = 5'h12;
   localparam logic [4:0] S = 5'h13;

   typedef struct {
      logic        rst, fiq, irq, swi, ret;
      logic [31:0] pc, lr;
      logic [4:0]  m;
      logic [1:0]  mask;
      logic        stall, wpc;
      logic [31:0] pcn;
      logic        wreg;
      logic [31:0] wdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t tbl[$];

   exc_mode_ctrl_if #(.ADDR(4), .SIZE(32)) bus ();

   exc_mode_ctrl dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, f, q, s, t,
                      input logic [31:0] pc, lr,
                      input logic [4:0] m, input logic [1:0] mask,
                      input logic st, wpc, input logic [31:0] pcn,
                      input logic wreg, input logic [31:0] wd);
      vec_t v;
      v.rst = r; v.fiq = f; v.irq = q; v.swi = s; v.ret = t;
      v.pc = pc; v.lr = lr; v.m = m; v.mask = mask;
      v.stall = st; v.wpc = wpc; v.pcn = pcn;
      v.wreg = wreg; v.wdata = wd;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic r, f, q, s, t,
                        input logic [31:0] pc, lr);
      rst = r;
      bus.Fiq_Req = f; bus.Irq_Req = q;
      bus.Swi_Req = s; bus.Ret_Req = t;
      bus.PC = pc; bus.Lr_Data = lr;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // reset, then return from SVC
      add(1,0,0,0,0, 32'h0,   32'h0,    S,2'd3,1,1,32'h0,   0,32'h0);
      add(0,0,0,0,0, 32'h0,   32'h0,    S,2'd3,0,0,32'h0,   0,32'h0);
      add(0,0,0,0,1, 32'h100, 32'h0,    S,2'd3,1,0,32'h0,   0,32'h0);
      add(0,0,0,0,0, 32'h100, 32'h2000, S,2'd3,1,1,32'h2000,0,32'h0);
      add(0,0,0,0,0, 32'h100, 32'h0,    U,2'd0,0,0,32'h0,   0,32'h0);
      // return from USR is ignored
      add(0,0,0,0,1, 32'h100, 32'h0,    U,2'd0,0,0,32'h0,   0,32'h0);
      // IRQ from USR
      add(0,0,1,0,0, 32'h40,  32'h0,    I,2'd1,1,0,32'h0,   1,32'h40);
      add(0,0,1,0,0, 32'h44,  32'h0,    I,2'd1,1,1,32'h18,  0,32'h0);
      add(0,0,1,0,0, 32'h44,  32'h0,    I,2'd1,0,0,32'h0,   0,32'h0);
      // FIQ inside IRQ handler
      add(0,1,1,0,0, 32'h60,  32'h0,    F,2'd3,1,0,32'h0,   1,32'h60);
      add(0,1,1,0,0, 32'h64,  32'h0,    F,2'd3,1,1,32'h1C,  0,32'h0);
      add(0,1,1,0,0, 32'h64,  32'h0,    F,2'd3,0,0,32'h0,   0,32'h0);
      add(0,0,1,0,1, 32'h64,  32'h0,    F,2'd3,1,0,32'h0,   0,32'h0);
      add(0,0,1,0,0, 32'h64,  32'h64,   F,2'd3,1,1,32'h64,  0,32'h0);
`ifdef SPSR_EN
      add(0,0,0,0,0, 32'h64,  32'h0,    I,2'd1,0,0,32'h0,   0,32'h0);
      add(0,0,0,0,1, 32'h64,  32'h0,    I,2'd1,1,0,32'h0,   0,32'h0);
      add(0,0,0,0,0, 32'h64,  32'h48,   I,2'd1,1,1,32'h48,  0,32'h0);
`else
      add(0,0,0,0,0, 32'h64,  32'h0,    U,2'd0,0,0,32'h0,   0,32'h0);
      add(0,0,0,0,1, 32'h64,  32'h0,    U,2'd0,0,0,32'h0,   0,32'h0);
      add(0,0,0,0,0, 32'h64,  32'h48,   U,2'd0,0,0,32'h0,   0,32'h0);
`endif
      add(0,0,0,0,0, 32'h64,  32'h0,    U,2'd0,0,0,32'h0,   0,32'h0);
      // FIQ and IRQ together: FIQ first, IRQ held off until return
      add(0,1,1,0,0, 32'h80,  32'h0,    F,2'd3,1,0,32'h0,   1,32'h80);
      add(0,1,1,0,0, 32'h84,  32'h0,    F,2'd3,1,1,32'h1C,  0,32'h0);
      add(0,1,1,0,0, 32'h84,  32'h0,    F,2'd3,0,0,32'h0,   0,32'h0);
      add(0,0,1,0,1, 32'h84,  32'h0,    F,2'd3,1,0,32'h0,   0,32'h0);
      add(0,0,1,0,0, 32'h84,  32'h84,   F,2'd3,1,1,32'h84,  0,32'h0);
      add(0,0,1,0,0, 32'h84,  32'h0,    U,2'd0,0,0,32'h0,   0,32'h0);
      add(0,0,1,0,0, 32'h90,  32'h0,    I,2'd1,1,0,32'h0,   1,32'h90);
      add(0,0,0,0,0, 32'h94,  32'h0,    I,2'd1,1,1,32'h18,  0,32'h0);
      add(0,0,0,0,0, 32'h94,  32'h0,    I,2'd1,0,0,32'h0,   0,32'h0);
      // SWI from IRQ; a SWI held into SAVE is dropped
      add(0,0,0,1,0, 32'hA0,  32'h0,    S,2'd1,1,0,32'h0,   1,32'hA0);
      add(0,0,0,1,0, 32'hA4,  32'h0,    S,2'd1,1,1,32'h08,  0,32'h0);
      add(0,0,0,0,0, 32'hA4,  32'h0,    S,2'd1,0,0,32'h0,   0,32'h0);
      add(0,0,0,0,1, 32'hA4,  32'h0,    S,2'd1,1,0,32'h0,   0,32'h0);
      add(0,0,0,0,0, 32'hA4,  32'hA4,   S,2'd1,1,1,32'hA4,  0,32'h0);
`ifdef SPSR_EN
      add(0,0,0,0,0, 32'hA4,  32'h0,    I,2'd1,0,0,32'h0,   0,32'h0);
`else
      add(0,0,0,0,0, 32'hA4,  32'h0,    U,2'd0,0,0,32'h0,   0,32'h0);
`endif

      foreach (tbl[k]) begin
         @(negedge clk);
         drive(tbl[k].rst, tbl[k].fiq, tbl[k].irq, tbl[k].swi,
               tbl[k].ret, tbl[k].pc, tbl[k].lr);
         @(posedge clk);
         #1;
         chk($sformatf("r%0d M", k), 32'(bus.M), 32'(tbl[k].m));
         chk($sformatf("r%0d Mask", k), 32'(bus.Mask), 32'(tbl[k].mask));
         chk($sformatf("r%0d Stall", k), 32'(bus.Stall), 32'(tbl[k].stall));
         chk($sformatf("r%0d Write_PC", k), 32'(bus.Write_PC),
             32'(tbl[k].wpc));
         chk($sformatf("r%0d Write_Reg", k), 32'(bus.Write_Reg),
             32'(tbl[k].wreg));
         if (tbl[k].wpc)
            chk($sformatf("r%0d PC_New", k), bus.PC_New, tbl[k].pcn);
         if (tbl[k].wreg)
            chk($sformatf("r%0d W_Data", k), bus.W_Data, tbl[k].wdata);
      end

      chk("W_Addr", 32'(bus.W_Addr), 32'd14);
      chk("Rd_Addr", 32'(bus.Rd_Addr), 32'd14);

      // reset while in SAVE: write suppressed, sequence aborted
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC0, 32'h0);
      @(posedge clk);
      #1;
      chk("rs SAVE Write_Reg", 32'(bus.Write_Reg), 32'd1);
      chk("rs SAVE M", 32'(bus.M), 32'(S));
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC4, 32'h0);
      #1;
      chk("rs edge Write_Reg", 32'(bus.Write_Reg), 32'd0);
      @(posedge clk);
      #1;
      chk("rs M", 32'(bus.M), 32'(S));
      chk("rs Mask", 32'(bus.Mask), 32'd3);
      chk("rs Write_PC", 32'(bus.Write_PC), 32'd1);
      chk("rs PC_New", bus.PC_New, 32'h0);
      chk("rs Write_Reg", 32'(bus.Write_Reg), 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC4, 32'h0);
      @(posedge clk);
      #1;
      chk("rs idle Stall", 32'(bus.Stall), 32'd0);
      chk("rs idle Write_PC", 32'(bus.Write_PC), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
